// File: rtl/video_timing_rx.sv
// Receive-side 720p timing monitor: recovers pixel coordinates, measures sync timing and tracks lock.
// Define FRAME_CHECKSUM_EN to add a per-frame 16-bit (r+g+b) checksum on frame_sum.
module video_timing_rx #(
  parameter int EXP_H_TOTAL  = 1650,
  parameter int EXP_V_TOTAL  = 750,
  parameter int EXP_H_ACTIVE = 1280,
  parameter int EXP_V_ACTIVE = 720,
  parameter int LOCK_FRAMES  = 2,
  parameter int TIMEOUT_CLKS = 3300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_hs,
  input  logic        in_vs,
  input  logic        in_de,
  input  logic [7:0]  in_r,
  input  logic [7:0]  in_g,
  input  logic [7:0]  in_b,
  output logic        rx_valid,
  output logic [11:0] rx_x,
  output logic [11:0] rx_y,
  output logic [23:0] rx_rgb,
  output logic        rx_sof,
  output logic [11:0] h_total_meas,
  output logic [11:0] v_total_meas,
  output logic [11:0] h_active_meas,
  output logic [11:0] v_active_meas,
  output logic        locked,
  output logic        err_sticky,
  output logic [15:0] frame_sum
);

  typedef enum logic [1:0] {ST_UNLOCKED, ST_CHECK, ST_LOCKED} state_t;

  localparam logic [11:0] EXP_HT = 12'(EXP_H_TOTAL);
  localparam logic [11:0] EXP_VT = 12'(EXP_V_TOTAL);
  localparam logic [11:0] EXP_HA = 12'(EXP_H_ACTIVE);
  localparam logic [11:0] EXP_VA = 12'(EXP_V_ACTIVE);
  localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);
  localparam logic [11:0] TO_LIM = 12'(TIMEOUT_CLKS);

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic [11:0] h_cnt_q, h_cnt_d, de_run_q, de_run_d;
  logic [11:0] line_cnt_q, line_cnt_d, act_lines_q, act_lines_d;
  logic [11:0] to_cnt_q, to_cnt_d;
  logic [11:0] h_total_q, h_total_d, v_total_q, v_total_d;
  logic [11:0] h_active_q, h_active_d, v_active_q, v_active_d;
  logic        rx_valid_q, rx_valid_d, rx_sof_q, rx_sof_d, sof_pend_q, sof_pend_d;
  logic [11:0] rx_x_q, rx_x_d, rx_y_q, rx_y_d;
  logic [23:0] rx_rgb_q, rx_rgb_d;
  state_t      state_q, state_d;
  logic [3:0]  match_cnt_q, match_cnt_d, cnt_inc;
  logic        arm_q, arm_d, locked_q, locked_d, err_q, err_d;

  logic        hs_rise, vs_rise, de_rise, de_fall, timeout, match;
  logic [11:0] h_tot_now, h_act_now;

  assign hs_rise = in_hs & ~hs_q;
  assign vs_rise = in_vs & ~vs_q;
  assign de_rise = in_de & ~de_q;
  assign de_fall = ~in_de & de_q;
  assign timeout = ~hs_rise && (to_cnt_q == TO_LIM - 12'd1);

  // Horizontal values updating on this very edge are compared in their new form.
  assign h_tot_now = hs_rise ? h_cnt_q : h_total_q;
  assign h_act_now = de_fall ? de_run_q : h_active_q;
  assign match     = (h_tot_now == EXP_HT) && (line_cnt_q == EXP_VT) &&
                     (h_act_now == EXP_HA) && (act_lines_q == EXP_VA);
  assign cnt_inc   = match_cnt_q + 4'd1;

  always_comb begin
    hs_d        = in_hs;
    vs_d        = in_vs;
    de_d        = in_de;
    h_total_d   = h_total_q;
    h_active_d  = h_active_q;
    v_total_d   = v_total_q;
    v_active_d  = v_active_q;
    line_cnt_d  = line_cnt_q;
    act_lines_d = act_lines_q;
    de_run_d    = de_run_q;

    h_cnt_d = hs_rise ? 12'd1 : sat_inc(h_cnt_q);
    if (hs_rise) h_total_d = h_cnt_q;

    if (de_fall) begin
      h_active_d = de_run_q;
      de_run_d   = '0;
    end else if (in_de) begin
      de_run_d = sat_inc(de_run_q);
    end

    // Edges coinciding with a vs rise belong to the new frame.
    if (vs_rise) begin
      v_total_d   = line_cnt_q;
      v_active_d  = act_lines_q;
      line_cnt_d  = hs_rise ? 12'd1 : 12'd0;
      act_lines_d = de_fall ? 12'd1 : 12'd0;
    end else begin
      if (hs_rise) line_cnt_d = sat_inc(line_cnt_q);
      if (de_fall) act_lines_d = sat_inc(act_lines_q);
    end

    if (hs_rise) to_cnt_d = '0;
    else if (to_cnt_q != TO_LIM) to_cnt_d = to_cnt_q + 12'd1;
    else to_cnt_d = to_cnt_q;

    rx_valid_d = in_de;
    rx_rgb_d   = {in_r, in_g, in_b};
    rx_x_d     = rx_x_q;
    rx_y_d     = rx_y_q;
    if (de_rise) rx_x_d = '0;
    else if (in_de) rx_x_d = sat_inc(rx_x_q);
    if (vs_rise) rx_y_d = '0;
    else if (de_fall) rx_y_d = sat_inc(rx_y_q);

    sof_pend_d = sof_pend_q | vs_rise;
    rx_sof_d   = de_rise & sof_pend_d;
    if (de_rise) sof_pend_d = 1'b0;

    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    arm_d       = arm_q;
    err_d       = err_q;
    if (timeout) begin
      state_d     = ST_UNLOCKED;
      match_cnt_d = '0;
      arm_d       = 1'b0;
      if (state_q == ST_LOCKED) err_d = 1'b1;
    end else if (vs_rise) begin
      if (!arm_q) begin
        arm_d = 1'b1;
      end else begin
        case (state_q)
          ST_UNLOCKED: begin
            if (match) begin
              match_cnt_d = 4'd1;
              state_d     = (LOCK_N <= 4'd1) ? ST_LOCKED : ST_CHECK;
            end else begin
              match_cnt_d = '0;
            end
          end
          ST_CHECK: begin
            if (match) begin
              match_cnt_d = cnt_inc;
              if (cnt_inc >= LOCK_N) state_d = ST_LOCKED;
            end else begin
              match_cnt_d = '0;
              state_d     = ST_UNLOCKED;
            end
          end
          ST_LOCKED: begin
            if (!match) begin
              match_cnt_d = '0;
              state_d     = ST_UNLOCKED;
              err_d       = 1'b1;
            end
          end
          default: begin
            match_cnt_d = '0;
            state_d     = ST_UNLOCKED;
          end
        endcase
      end
    end
    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q <= 1'b0; vs_q <= 1'b0; de_q <= 1'b0;
      h_cnt_q <= '0; de_run_q <= '0; line_cnt_q <= '0; act_lines_q <= '0; to_cnt_q <= '0;
      h_total_q <= '0; v_total_q <= '0; h_active_q <= '0; v_active_q <= '0;
      rx_valid_q <= 1'b0; rx_x_q <= '0; rx_y_q <= '0; rx_rgb_q <= '0;
      rx_sof_q <= 1'b0; sof_pend_q <= 1'b0;
      state_q <= ST_UNLOCKED; match_cnt_q <= '0; arm_q <= 1'b0;
      locked_q <= 1'b0; err_q <= 1'b0;
    end else begin
      hs_q <= hs_d; vs_q <= vs_d; de_q <= de_d;
      h_cnt_q <= h_cnt_d; de_run_q <= de_run_d; line_cnt_q <= line_cnt_d;
      act_lines_q <= act_lines_d; to_cnt_q <= to_cnt_d;
      h_total_q <= h_total_d; v_total_q <= v_total_d;
      h_active_q <= h_active_d; v_active_q <= v_active_d;
      rx_valid_q <= rx_valid_d; rx_x_q <= rx_x_d; rx_y_q <= rx_y_d; rx_rgb_q <= rx_rgb_d;
      rx_sof_q <= rx_sof_d; sof_pend_q <= sof_pend_d;
      state_q <= state_d; match_cnt_q <= match_cnt_d; arm_q <= arm_d;
      locked_q <= locked_d; err_q <= err_d;
    end
  end

`ifdef FRAME_CHECKSUM_EN
  logic [15:0] acc_q, acc_d, frame_sum_q, frame_sum_d;

  always_comb begin
    acc_d       = vs_rise ? 16'd0 : acc_q;
    frame_sum_d = vs_rise ? acc_q : frame_sum_q;
    if (in_de) acc_d = acc_d + 16'(in_r) + 16'(in_g) + 16'(in_b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      frame_sum_q <= '0;
    end else begin
      acc_q       <= acc_d;
      frame_sum_q <= frame_sum_d;
    end
  end

  assign frame_sum = frame_sum_q;
`else
  assign frame_sum = '0;
`endif

  assign rx_valid      = rx_valid_q;
  assign rx_x          = rx_x_q;
  assign rx_y          = rx_y_q;
  assign rx_rgb        = rx_rgb_q;
  assign rx_sof        = rx_sof_q;
  assign h_total_meas  = h_total_q;
  assign v_total_meas  = v_total_q;
  assign h_active_meas = h_active_q;
  assign v_active_meas = v_active_q;
  assign locked        = locked_q;
  assign err_sticky    = err_q;

endmodule

// File: tb/tb_video_timing_rx.sv
// Scoreboard bench for video_timing_rx using a scaled-down raster and a frame-level lock model.
module tb_video_timing_rx;

  localparam int HT = 40, HA = 24, VT = 16, VA = 10, LF = 2, TO = 80;
  localparam int HS_W = 4, DE_X0 = 6, VS_W = 2, ACT_Y0 = 3;

  logic        clk = 1'b0, rst = 1'b1;
  logic        in_hs = 1'b0, in_vs = 1'b0, in_de = 1'b0;
  logic [7:0]  in_r = '0, in_g = '0, in_b = '0;
  logic        rx_valid, rx_sof, locked, err_sticky;
  logic [11:0] rx_x, rx_y, h_total_meas, v_total_meas, h_active_meas, v_active_meas;
  logic [23:0] rx_rgb;
  logic [15:0] frame_sum;

  video_timing_rx #(
    .EXP_H_TOTAL(HT), .EXP_V_TOTAL(VT), .EXP_H_ACTIVE(HA), .EXP_V_ACTIVE(VA),
    .LOCK_FRAMES(LF), .TIMEOUT_CLKS(TO)
  ) dut (
    .clk(clk), .rst(rst), .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .rx_valid(rx_valid), .rx_x(rx_x), .rx_y(rx_y), .rx_rgb(rx_rgb), .rx_sof(rx_sof),
    .h_total_meas(h_total_meas), .v_total_meas(v_total_meas),
    .h_active_meas(h_active_meas), .v_active_meas(v_active_meas),
    .locked(locked), .err_sticky(err_sticky), .frame_sum(frame_sum)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned tgt;
    logic [11:0] x, y;
    logic [23:0] rgb;
    logic        sof;
  } pix_t;

  typedef struct {
    int unsigned tgt;
    bit          meas, sum_chk;
    logic [11:0] h_tot;
    logic        lck, err;
    logic [15:0] sum;
  } ev_t;

  pix_t pq[$];
  ev_t  eq[$];
  int   n_chk = 0, n_fail = 0;

  // Frame-level reference state
  bit          armed = 0, locked_e = 0, err_e = 0, fr_full = 0, fr_ok = 0, sof_pend = 0;
  int          streak = 0, last_len = 0, row_e = 0;
  logic [15:0] sum_e = '0;
  int unsigned hs_tgt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input logic hs, input logic vs, input logic de,
                      input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    in_hs = hs; in_vs = vs; in_de = de; in_r = r; in_g = g; in_b = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero();
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_x", rx_x, 0);
    check("rst_rx_y", rx_y, 0);
    check("rst_rx_rgb", rx_rgb, 0);
    check("rst_rx_sof", rx_sof, 0);
    check("rst_h_total", h_total_meas, 0);
    check("rst_v_total", v_total_meas, 0);
    check("rst_h_active", h_active_meas, 0);
    check("rst_v_active", v_active_meas, 0);
    check("rst_locked", locked, 0);
    check("rst_err", err_sticky, 0);
    check("rst_frame_sum", frame_sum, 0);
  endtask

  task automatic model_reset();
    armed = 0; streak = 0; locked_e = 0; err_e = 0;
    fr_full = 0; fr_ok = 0; sum_e = '0; row_e = 0; sof_pend = 0;
  endtask

  task automatic vs_event();
    ev_t e;
    e.tgt = cyc + 1;
    e.meas = fr_full;
    e.sum_chk = 1;
    e.h_tot = 12'(last_len);
    if (!armed) armed = 1;
    else if (fr_full && fr_ok) streak++;
    else begin
      if (locked_e) err_e = 1;
      streak = 0;
    end
    locked_e = armed && (streak >= LF);
    e.lck = locked_e;
    e.err = err_e;
`ifdef FRAME_CHECKSUM_EN
    e.sum = sum_e;
`else
    e.sum = '0;
`endif
    eq.push_back(e);
    sum_e = '0; fr_full = 1; fr_ok = 1; row_e = 0; sof_pend = 1;
  endtask

  task automatic run_line(input int l, input int len, input bit constc, input bit tp);
    bit act;
    logic hs, vs, de;
    logic [7:0] r, g, b;
    pix_t p;
    act = (l >= ACT_Y0) && (l < ACT_Y0 + VA);
    for (int c = 0; c < len; c++) begin
      hs = (c < HS_W);
      vs = (l < VS_W);
      de = act && (c >= DE_X0) && (c < DE_X0 + HA);
      if (constc) begin
        r = 8'd1; g = 8'd2; b = 8'd3;
      end else begin
        r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
      end
      if (tp && l == ACT_Y0 + 3 && c == DE_X0 + 5) begin
        r = 8'hAA; g = 8'h00; b = 8'h00;
      end
      if (c == 0) hs_tgt = cyc + 1;
      if (l == 0 && c == 0) vs_event();
      if (de) begin
        p.tgt = cyc + 1;
        p.x = 12'(c - DE_X0);
        p.y = 12'(row_e);
        p.rgb = {r, g, b};
        p.sof = sof_pend;
        sof_pend = 0;
        pq.push_back(p);
        sum_e = sum_e + 16'(r) + 16'(g) + 16'(b);
      end
      tick(hs, vs, de, r, g, b);
    end
    if (act) row_e++;
    last_len = len;
    if (len != HT) fr_ok = 0;
  endtask

  task automatic mid_reset();
    rst = 1'b1;
    tick(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_zero();
  endtask

  task automatic run_frame(input bit short_last, input bit constc, input bit tp, input int rst_line);
    for (int l = 0; l < VT; l++) begin
      run_line(l, (short_last && l == VT - 1) ? HT - 1 : HT, constc, tp);
      if (l == rst_line) mid_reset();
    end
  endtask

  always @(negedge clk) begin
    ev_t  e;
    pix_t p;
    while (eq.size() > 0 && eq[0].tgt < cyc) begin
      e = eq.pop_front();
      check("event_missed", cyc, e.tgt);
    end
    if (eq.size() > 0 && eq[0].tgt == cyc) begin
      e = eq.pop_front();
      check("locked", locked, e.lck);
      check("err_sticky", err_sticky, e.err);
      if (e.sum_chk) check("frame_sum", frame_sum, e.sum);
      if (e.meas) begin
        check("h_total_meas", h_total_meas, e.h_tot);
        check("v_total_meas", v_total_meas, VT);
        check("h_active_meas", h_active_meas, HA);
        check("v_active_meas", v_active_meas, VA);
      end
    end
    if (rx_valid) begin
      if (pq.size() == 0) begin
        check("rx_valid_unexpected", rx_valid, 0);
      end else begin
        p = pq.pop_front();
        check("pix_time", cyc, p.tgt);
        check("rx_x", rx_x, p.x);
        check("rx_y", rx_y, p.y);
        check("rx_rgb", rx_rgb, p.rgb);
        check("rx_sof", rx_sof, p.sof);
      end
    end else begin
      if (rx_sof) check("rx_sof_idle", rx_sof, 0);
      if (pq.size() > 0 && pq[0].tgt < cyc) begin
        p = pq.pop_front();
        check("pix_missing", cyc, p.tgt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    ev_t e;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero();
    rst = 1'b0;
    model_reset();

    // Lock from reset; test pixel in frame 1, constant-colour frame 3
    run_frame(0, 0, 0, -1);
    run_frame(0, 0, 1, -1);
    run_frame(0, 0, 0, -1);
    run_frame(0, 1, 0, -1);

    // Short last line breaks lock, then relock
    run_frame(1, 0, 0, -1);
    run_frame(0, 0, 0, -1);
    run_frame(0, 0, 0, -1);
    run_frame(0, 0, 0, -1);

    // Reset in the middle of a frame, then relock
    run_frame(0, 0, 0, $urandom_range(4, 12));
    run_frame(0, 0, 0, -1);
    run_frame(0, 0, 0, -1);
    run_frame(0, 0, 0, -1);

    // Hsync stops while locked
    run_line(0, HT, 0, 0);
    run_line(1, HT, 0, 0);
    run_line(2, HT, 0, 0);
    e.meas = 0; e.sum_chk = 0; e.h_tot = '0; e.sum = '0;
    e.tgt = hs_tgt + TO - 1; e.lck = locked_e; e.err = err_e;
    eq.push_back(e);
    if (locked_e) err_e = 1;
    locked_e = 0; armed = 0; streak = 0; fr_full = 0;
    e.tgt = hs_tgt + TO; e.lck = 0; e.err = err_e;
    eq.push_back(e);
    repeat (TO + 10) tick(0, 0, 0, 0, 0, 0);

    run_frame(0, 0, 0, -1);
    run_frame(0, 0, 0, -1);
    run_frame(0, 0, 0, -1);
    run_line(0, HT, 0, 0);
    repeat (5) tick(0, 0, 0, 0, 0, 0);

    @(negedge clk);
    check("pix_queue_empty", pq.size(), 0);
    check("event_queue_empty", eq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
